// File: rtl/mem_arbiter_rr_pkg.sv
// rtl/mem_arbiter_rr_pkg.sv - shared state encoding and width helper for the memory arbiter
package mem_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  // Index width for n items, never narrower than one bit
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin winner select starting after ptr
module rr_picker
  import mem_arbiter_rr_pkg::*;
#(
  parameter int N = 3,
  parameter int W = ch_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  int idx;

  // Scan downward so the last hit (closest to ptr+1) wins
  always_comb begin
    winner = '0;
    idx    = 0;
    any    = |req;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) winner = W'(idx);
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-channel arbiter onto a single memory port, one transaction in flight
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255,
  parameter int CH_W    = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_rw,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ack,
  output logic [NUM_CH-1:0]        req_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [CH_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     mem_enable,
  output logic                     mem_rw,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_data_out
);

  localparam int TIMER_W = ch_width(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CH_W-1:0]    PTR_INIT   = CH_W'(NUM_CH - 1);

  arb_state_t          state, next_state;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     pick_ptr;
  logic [CH_W-1:0]     winner;
  logic                any;
  logic [TIMER_W-1:0]  timer;
  logic                expired;
  logic                finish;
  logic [NUM_CH-1:0]   grant_onehot;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Fixed priority is a round-robin scan that always starts just after the top channel
  assign pick_ptr = (RR_MODE != 0) ? rr_ptr : PTR_INIT;

  rr_picker #(.N(NUM_CH), .W(CH_W)) u_picker (
    .req    (req_valid),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: if (any) next_state = ARB_BUSY;
      ARB_BUSY: if (finish) next_state = ARB_DONE;
      ARB_DONE: next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    expired      = (TIMEOUT != 0) && (timer == TIMER_LAST);
    finish       = (state == ARB_BUSY) && (mem_ack || expired);
    grant_onehot = NUM_CH'(1) << grant_id;
    sel_rw       = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(winner) == i) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ack     <= '0;
      req_err     <= '0;
      rsp_rdata   <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      mem_enable  <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rr_ptr      <= PTR_INIT;
      timer       <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      case (state)
        ARB_IDLE: begin
          if (any) begin
            mem_enable  <= 1'b1;
            busy        <= 1'b1;
            grant_id    <= winner;
            mem_rw      <= sel_rw;
            mem_addr    <= sel_addr;
            mem_data_in <= sel_wdata;
            timer       <= '0;
          end
        end
        ARB_BUSY: begin
          timer <= timer + 1'b1;
          if (finish) begin
            // An ack landing on the expiry cycle still counts as success
            req_ack    <= grant_onehot;
            req_err    <= mem_ack ? '0 : grant_onehot;
            mem_enable <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= grant_id;
            if (mem_ack && !mem_rw) rsp_rdata <= mem_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
